// File: rtl/slp_bool_weight_bank_pkg.sv
// Shared types for the boolean-input single-layer perceptron weight bank:
// weight-precision configuration record and controller state encoding.
package slp_bool_weight_bank_pkg;

  typedef struct packed {
    int unsigned n_in;
    int unsigned w_prec;
  } dconf_t;

  localparam dconf_t DCONF_DEFAULT = '{n_in: 32'd8, w_prec: 32'd8};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2,
    ST_UPD  = 2'd3
  } state_e;

endpackage

// File: rtl/slp_bool_weight_bank_calc.sv
// Single-weight update rule, time-shared across all indices of the bank.
// Agreement between input and target pushes the weight up, disagreement down.
module slp_calc_bool_weight
  import slp_bool_weight_bank_pkg::*;
#(
  parameter int W_PREC = int'(DCONF_DEFAULT.w_prec)
) (
  input  logic                     in_bit,
  input  logic                     target,
  input  logic signed [W_PREC-1:0] w_in,
  output logic signed [W_PREC-1:0] w_out
);

  localparam logic signed [W_PREC-1:0] W_MAX  = {1'b0, {(W_PREC-1){1'b1}}};
  localparam logic signed [W_PREC-1:0] W_ZERO = {W_PREC{1'b0}};
  localparam logic signed [W_PREC-1:0] W_ONE  = {{(W_PREC-1){1'b0}}, 1'b1};

  // Saturating increment on agreement, floor-at-zero decrement otherwise.
  always_comb begin
    w_out = w_in;
    if (in_bit ~^ target) begin
      if (w_in < W_MAX) begin
        w_out = w_in + W_ONE;
      end else begin
        w_out = w_in;
      end
    end else begin
      if (w_in > W_ZERO) begin
        w_out = w_in - W_ONE;
      end else begin
        w_out = w_in;
      end
    end
  end

endmodule

// File: rtl/slp_bool_weight_bank.sv
// Boolean-input perceptron: serial dot product over N_IN inputs plus bias,
// handshaked result, and optional serial weight update on misclassification.
module slp_bool_weight_bank
  import slp_bool_weight_bank_pkg::*;
#(
  parameter int N_IN   = int'(DCONF_DEFAULT.n_in),
  parameter int W_PREC = int'(DCONF_DEFAULT.w_prec)
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_IN-1:0]               in_vec,
  input  logic                          target,
  input  logic                          train,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_result,
  output logic                          out_error,
  input  logic [$clog2(N_IN+1)-1:0]     rd_idx,
  output logic signed [W_PREC-1:0]      rd_weight
);

  localparam int IW = $clog2(N_IN + 1);
  localparam int AW = W_PREC + IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [N_IN-1:0]          vec_q, vec_d;
  logic                     tgt_q, tgt_d;
  logic                     trn_q, trn_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_result_q, out_result_d;
  logic                     out_error_q, out_error_d;
  logic signed [W_PREC-1:0] w_q [N_IN+1];
  logic signed [W_PREC-1:0] w_d [N_IN+1];

  logic [N_IN:0]            x_vec;
  logic                     x_bit;
  logic signed [W_PREC-1:0] w_sel;
  logic signed [AW-1:0]     w_ext;
  logic signed [W_PREC-1:0] w_upd;

  // The bias sits at index N_IN with a constant +1 input.
  assign x_vec = {1'b1, vec_q};
  assign x_bit = x_vec[idx_q];
  assign w_sel = w_q[idx_q];
  assign w_ext = {{(AW-W_PREC){w_sel[W_PREC-1]}}, w_sel};

  slp_calc_bool_weight #(.W_PREC(W_PREC)) u_calc (
    .in_bit (x_bit),
    .target (tgt_q),
    .w_in   (w_sel),
    .w_out  (w_upd)
  );

  // Next-state and datapath decode for the IDLE/ACC/RESP/UPD controller.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    vec_d        = vec_q;
    tgt_d        = tgt_q;
    trn_d        = trn_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_error_d  = out_error_q;
    w_d          = w_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          vec_d   = in_vec;
          tgt_d   = target;
          trn_d   = train;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_ACC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (x_bit) begin
          acc_d = acc_q + w_ext;
        end else begin
          acc_d = acc_q - w_ext;
        end
        if (idx_q == LAST_IDX) begin
          idx_d        = '0;
          out_valid_d  = 1'b1;
          out_result_d = ~acc_d[AW-1];
          out_error_d  = ~acc_d[AW-1] ^ tgt_q;
          state_d      = ST_RESP;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          idx_d       = '0;
          state_d     = (trn_q && out_error_q) ? ST_UPD : ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_UPD: begin
        w_d[idx_q] = w_upd;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State, datapath and weight registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      vec_q        <= '0;
      tgt_q        <= 1'b0;
      trn_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_result_q <= 1'b0;
      out_error_q  <= 1'b0;
      for (int i = 0; i <= N_IN; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      vec_q        <= vec_d;
      tgt_q        <= tgt_d;
      trn_q        <= trn_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_error_q  <= out_error_d;
      w_q          <= w_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_error  = out_error_q;

  // Combinational weight readout; indices past the bias read as zero.
  always_comb begin
    if (rd_idx <= LAST_IDX) begin
      rd_weight = w_q[rd_idx];
    end else begin
      rd_weight = '0;
    end
  end

endmodule
